top_memoryaccess: RTL and testbench

Memory-access stage of the RockWave multi-cycle RV32I core. It sits directly downstream of top_execute and consumes its *_em outputs during phase_memoryaccess. It performs loads and stores on the data memory through a req/ack handshake, aligns and extends load data, and registers the results for writeback (*_mw). It stalls the state machine while an access is outstanding.

---
 rtl/top_memoryaccess_pkg.sv | 21 ++
 rtl/top_memoryaccess_mem_align.sv | 68 ++++++
 rtl/top_memoryaccess.sv | 127 ++++++++++++
 tb/tb_top_memoryaccess.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/top_memoryaccess_pkg.sv
// Shared constants for the memory-access stage: widths, decoded-op field
// positions, load/store funct3 codes and the access FSM states.
package top_memoryaccess_pkg;
   localparam int XLEN          = 32;
   localparam int OPLEN         = 9;
   localparam int FUNCT3_BIT_M  = 2;
   localparam int FUNCT3_BIT_L  = 0;
   localparam int USE_LOAD_BIT  = 3;
   localparam int USE_STORE_BIT = 4;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} ma_state_e;
endpackage

// File: rtl/top_memoryaccess_mem_align.sv
// Combinational lane logic: store strobes/replication, legality check, and
// load byte/half extraction with sign or zero extension.
module mem_align
   import top_memoryaccess_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      off_i,
   input  logic            is_load_i,
   input  logic            is_store_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic [3:0]      we_o,
   output logic [XLEN-1:0] wdata_o,
   output logic            bad_o,
   input  logic [2:0]      ld_funct3_i,
   input  logic [1:0]      ld_off_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] ld_data_o
);
   logic [XLEN-1:0] shifted;
   logic [15:0]     half;

   always_comb begin
      bad_o   = 1'b0;
      we_o    = 4'b0000;
      wdata_o = rs2_i;
      if (is_load_i && is_store_i) begin
         bad_o = 1'b1;
      end else if (is_load_i) begin
         case (funct3_i)
            F3_LB, F3_LBU: bad_o = 1'b0;
            F3_LH, F3_LHU: bad_o = off_i[0];
            F3_LW:         bad_o = (off_i != 2'b00);
            default:       bad_o = 1'b1;
         endcase
      end else if (is_store_i) begin
         case (funct3_i)
            F3_SB: begin
               we_o    = 4'b0001 << off_i;
               wdata_o = {4{rs2_i[7:0]}};
            end
            F3_SH: begin
               bad_o   = off_i[0];
               we_o    = off_i[1] ? 4'b1100 : 4'b0011;
               wdata_o = {2{rs2_i[15:0]}};
            end
            F3_SW: begin
               bad_o = (off_i != 2'b00);
               we_o  = 4'b1111;
            end
            default: bad_o = 1'b1;
         endcase
      end
   end

   // Load side uses the offset/funct3 latched at issue, not the live inputs.
   always_comb begin
      shifted   = rdata_i >> {ld_off_i, 3'b000};
      half      = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      ld_data_o = rdata_i;
      case (ld_funct3_i)
         F3_LB:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU:  ld_data_o = {24'h0, shifted[7:0]};
         F3_LH:   ld_data_o = {{16{half[15]}}, half};
         F3_LHU:  ld_data_o = {16'h0, half};
         default: ld_data_o = rdata_i;
      endcase
   end
endmodule

// File: rtl/top_memoryaccess.sv
// Memory-access stage: issues data-memory loads/stores over req/ack, stalls
// while waiting, aborts on ack timeout, and registers results for writeback.
module top_memoryaccess
   import top_memoryaccess_pkg::*;
#(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             phase_memoryaccess,
   input  logic [OPLEN-1:0] decoded_op_em,
   input  logic             jump_state_em,
   input  logic [4:0]       rdsel_em,
   input  logic [XLEN-1:0]  next_pc_em,
   input  logic [XLEN-1:0]  alu_out_em,
   input  logic [XLEN-1:0]  rs2data_em,
   output logic             dmem_req,
   output logic [XLEN-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   output logic [3:0]       dmem_we,
   input  logic             dmem_ack,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             stall_memoryaccess,
   output logic [OPLEN-1:0] decoded_op_mw,
   output logic             jump_state_mw,
   output logic [4:0]       rdsel_mw,
   output logic [XLEN-1:0]  next_pc_mw,
   output logic [XLEN-1:0]  rddata_mw,
   output logic             misaligned_mw,
   output logic             bus_error_mw
);
   localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

   ma_state_e       state_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      off_q;
   logic            is_ld_q;
   logic            is_load, is_store, memop, bad;
   logic [3:0]      we_d;
   logic [XLEN-1:0] wdata_d, ld_data;

   assign is_load  = decoded_op_em[USE_LOAD_BIT];
   assign is_store = decoded_op_em[USE_STORE_BIT];
   assign memop    = is_load | is_store;

   mem_align u_align (
      .funct3_i    (decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L]),
      .off_i       (alu_out_em[1:0]),
      .is_load_i   (is_load),
      .is_store_i  (is_store),
      .rs2_i       (rs2data_em),
      .we_o        (we_d),
      .wdata_o     (wdata_d),
      .bad_o       (bad),
      .ld_funct3_i (decoded_op_mw[FUNCT3_BIT_M:FUNCT3_BIT_L]),
      .ld_off_i    (off_q),
      .rdata_i     (dmem_rdata),
      .ld_data_o   (ld_data)
   );

   assign stall_memoryaccess = (state_q == S_WAIT) |
                               ((state_q == S_IDLE) & phase_memoryaccess & memop & ~bad);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         off_q         <= '0;
         is_ld_q       <= 1'b0;
         dmem_req      <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_we       <= '0;
         decoded_op_mw <= '0;
         jump_state_mw <= 1'b0;
         rdsel_mw      <= '0;
         next_pc_mw    <= '0;
         rddata_mw     <= '0;
         misaligned_mw <= 1'b0;
         bus_error_mw  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (phase_memoryaccess) begin
               decoded_op_mw <= decoded_op_em;
               jump_state_mw <= jump_state_em;
               rdsel_mw      <= rdsel_em;
               next_pc_mw    <= next_pc_em;
               misaligned_mw <= 1'b0;
               bus_error_mw  <= 1'b0;
               if (!memop) begin
                  rddata_mw <= alu_out_em;
                  state_q   <= S_DONE;
               end else if (bad) begin
                  misaligned_mw <= 1'b1;
                  rddata_mw     <= '0;
                  state_q       <= S_DONE;
               end else begin
                  dmem_req   <= 1'b1;
                  dmem_addr  <= {alu_out_em[XLEN-1:2], 2'b00};
                  dmem_wdata <= wdata_d;
                  dmem_we    <= we_d;
                  off_q      <= alu_out_em[1:0];
                  is_ld_q    <= is_load;
                  cnt_q      <= '0;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (is_ld_q) rddata_mw <= ld_data;
                  state_q  <= S_DONE;
               end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                  dmem_req     <= 1'b0;
                  bus_error_mw <= 1'b1;
                  rddata_mw    <= '0;
                  state_q      <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DONE:  if (!phase_memoryaccess) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_top_memoryaccess.sv
// Scoreboard bench for the memory-access stage: expected writeback values are
// queued as each access is launched and compared when the stage finishes it.
module tb_top_memoryaccess;
   logic        clk = 1'b0;
   logic        rst;
   logic        phase_memoryaccess;
   logic [8:0]  decoded_op_em;
   logic        jump_state_em;
   logic [4:0]  rdsel_em;
   logic [31:0] next_pc_em, alu_out_em, rs2data_em;
   logic        dmem_req;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_we;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall_memoryaccess;
   logic [8:0]  decoded_op_mw;
   logic        jump_state_mw;
   logic [4:0]  rdsel_mw;
   logic [31:0] next_pc_mw, rddata_mw;
   logic        misaligned_mw, bus_error_mw;

   top_memoryaccess #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .phase_memoryaccess(phase_memoryaccess),
      .decoded_op_em(decoded_op_em), .jump_state_em(jump_state_em),
      .rdsel_em(rdsel_em), .next_pc_em(next_pc_em), .alu_out_em(alu_out_em),
      .rs2data_em(rs2data_em), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .stall_memoryaccess(stall_memoryaccess),
      .decoded_op_mw(decoded_op_mw), .jump_state_mw(jump_state_mw),
      .rdsel_mw(rdsel_mw), .next_pc_mw(next_pc_mw), .rddata_mw(rddata_mw),
      .misaligned_mw(misaligned_mw), .bus_error_mw(bus_error_mw)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        mis;
      logic        berr;
      logic [4:0]  rdsel;
      logic [31:0] npc;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] model_rd = '0;

   function automatic logic [8:0] mkop(input bit ld, input bit st, input logic [2:0] f3);
      return {4'b0000, st, ld, f3};
   endfunction

   // Launches one phase and follows it until stall drops; reports what the bus saw.
   task automatic run_access(input logic [8:0] op, input logic [31:0] alu, input logic [31:0] rs2,
                             input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] npc,
                             input int ack_at, output int stall_n, output int req_n,
                             output logic [31:0] a, output logic [3:0] we, output logic [31:0] wd,
                             output bit held, output bit hung);
      stall_n = 0; req_n = 0; held = 1; hung = 1; a = '0; we = '0; wd = '0;
      @(negedge clk);
      decoded_op_em = op; alu_out_em = alu; rs2data_em = rs2; dmem_rdata = rdata;
      rdsel_em = rd; next_pc_em = npc; jump_state_em = 1'b0;
      phase_memoryaccess = 1'b1; dmem_ack = 1'b0;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (!stall_memoryaccess) begin hung = 0; break; end
         stall_n++;
         if (dmem_req) begin
            if (req_n == 0) begin a = dmem_addr; we = dmem_we; wd = dmem_wdata; end
            else if (a !== dmem_addr || we !== dmem_we || wd !== dmem_wdata) held = 0;
            req_n++;
         end
         dmem_ack = dmem_req && (req_n == ack_at);
         @(negedge clk);
      end
      dmem_ack = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic end_phase();
      phase_memoryaccess = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; phase_memoryaccess = 1'b0; dmem_ack = 1'b0;
      decoded_op_em = '0; jump_state_em = 0; rdsel_em = '0; next_pc_em = '0;
      alu_out_em = '0; rs2data_em = '0; dmem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({dmem_req, stall_memoryaccess, misaligned_mw, bus_error_mw, jump_state_mw} !== 5'b0 ||
          rddata_mw !== 0 || rdsel_mw !== 0 || next_pc_mw !== 0 || decoded_op_mw !== 0 ||
          dmem_we !== 0 || dmem_addr !== 0) begin
         n_err++; $display("FAIL reset_state req=%b stall=%b rd=%h want all zero", dmem_req, stall_memoryaccess, rddata_mw);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_alu_passthrough();
      int sn, rn; logic [31:0] a, wd; logic [3:0] we; bit held, hung; exp_t e;
      sb.push_back('{32'h1234_5678, 1'b0, 1'b0, 5'h15, 32'hA0A0_A0A0});
      model_rd = 32'h1234_5678;
      run_access(9'h1A0, 32'h1234_5678, 32'h0, 32'h0, 5'h15, 32'hA0A0_A0A0, 0, sn, rn, a, we, wd, held, hung);
      e = sb.pop_front();
      n_cmp++; if (sn !== 0 || rn !== 0 || hung) begin n_err++; $display("FAIL alu_nostall stall_n=%0d req_n=%0d want 0/0", sn, rn); end
      n_cmp++; if (rddata_mw !== e.rd) begin n_err++; $display("FAIL alu_rddata got %h want %h", rddata_mw, e.rd); end
      n_cmp++; if (rdsel_mw !== e.rdsel || next_pc_mw !== e.npc) begin n_err++; $display("FAIL alu_passthru rdsel=%h pc=%h want %h %h", rdsel_mw, next_pc_mw, e.rdsel, e.npc); end
      n_cmp++; if (decoded_op_mw !== 9'h1A0) begin n_err++; $display("FAIL alu_op got %h want 1a0", decoded_op_mw); end
      end_phase();
   endtask

   task automatic test_loads();
      logic [2:0]  f3[6]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
      logic [31:0] ad[6]  = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h0, 32'h101};
      logic [31:0] rdt[6] = '{32'h80FF_0011, 32'h80FF_0011, 32'h8001_7FFF, 32'h8001_7FFF, 32'hCAFE_F00D, 32'h0000_7F00};
      logic [31:0] ex[6]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF, 32'hCAFE_F00D, 32'h0000_007F};
      int          ak[6]  = '{3, 3, 1, 2, 3, 1};
      int sn, rn; logic [31:0] a, wd; logic [3:0] we; bit held, hung; exp_t e;
      for (int i = 0; i < 6; i++) begin
         sb.push_back('{ex[i], 1'b0, 1'b0, 5'(i + 1), 32'h400 + 32'(i)});
         model_rd = ex[i];
         run_access(mkop(1, 0, f3[i]), ad[i], 32'hFFFF_FFFF, rdt[i], 5'(i + 1), 32'h400 + 32'(i), ak[i],
                    sn, rn, a, we, wd, held, hung);
         e = sb.pop_front();
         n_cmp++; if (hung || sn !== ak[i] + 1) begin n_err++; $display("FAIL load%0d_stall got %0d want %0d", i, sn, ak[i] + 1); end
         n_cmp++; if (a !== {ad[i][31:2], 2'b00} || we !== 4'b0) begin n_err++; $display("FAIL load%0d_bus addr=%h we=%b want %h 0000", i, a, we, {ad[i][31:2], 2'b00}); end
         n_cmp++; if (rddata_mw !== e.rd) begin n_err++; $display("FAIL load%0d_data got %h want %h", i, rddata_mw, e.rd); end
         n_cmp++; if (dmem_req !== 1'b0 || misaligned_mw !== e.mis || bus_error_mw !== e.berr || rdsel_mw !== e.rdsel) begin
            n_err++; $display("FAIL load%0d_flags req=%b mis=%b berr=%b rdsel=%h want 0 0 0 %h", i, dmem_req, misaligned_mw, bus_error_mw, rdsel_mw, e.rdsel);
         end
         end_phase();
      end
   endtask

   task automatic test_stores();
      logic [2:0]  f3[4] = '{3'b001, 3'b000, 3'b010, 3'b001};
      logic [31:0] ad[4] = '{32'h202, 32'h201, 32'h300, 32'h200};
      logic [31:0] r2[4] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D, 32'hA5A5_1234};
      logic [3:0]  xw[4] = '{4'b1100, 4'b0010, 4'b1111, 4'b0011};
      logic [31:0] xd[4] = '{32'hBEEF_BEEF, 32'h7878_7878, 32'h0BAD_F00D, 32'h1234_1234};
      int sn, rn; logic [31:0] a, wd; logic [3:0] we; bit held, hung; exp_t e;
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{model_rd, 1'b0, 1'b0, 5'h1F, 32'h800});
         run_access(mkop(0, 1, f3[i]), ad[i], r2[i], 32'h5555_5555, 5'h1F, 32'h800, 2,
                    sn, rn, a, we, wd, held, hung);
         e = sb.pop_front();
         n_cmp++; if (we !== xw[i] || wd !== xd[i]) begin n_err++; $display("FAIL store%0d_lanes we=%b wd=%h want %b %h", i, we, wd, xw[i], xd[i]); end
         n_cmp++; if (a !== {ad[i][31:2], 2'b00} || !held || rn !== 2 || hung) begin n_err++; $display("FAIL store%0d_hold addr=%h held=%0d req_n=%0d want %h 1 2", i, a, held, rn, {ad[i][31:2], 2'b00}); end
         n_cmp++; if (dmem_req !== 1'b0 || rddata_mw !== e.rd || misaligned_mw !== 1'b0) begin
            n_err++; $display("FAIL store%0d_after req=%b rd=%h mis=%b want 0 %h 0", i, dmem_req, rddata_mw, misaligned_mw, e.rd);
         end
         end_phase();
      end
   endtask

   task automatic test_illegal();
      logic [8:0]  op[6] = '{mkop(1,0,3'b010), mkop(1,0,3'b001), mkop(1,0,3'b011),
                            mkop(1,0,3'b110), mkop(0,1,3'b011), mkop(1,1,3'b010)};
      logic [31:0] ad[6] = '{32'h301, 32'h101, 32'h100, 32'h100, 32'h100, 32'h0};
      int sn, rn; logic [31:0] a, wd; logic [3:0] we; bit held, hung; exp_t e;
      for (int i = 0; i < 6; i++) begin
         sb.push_back('{32'h0, 1'b1, 1'b0, 5'h07, 32'h900});
         model_rd = '0;
         run_access(op[i], ad[i], 32'h1111_2222, 32'hFFFF_FFFF, 5'h07, 32'h900, 1,
                    sn, rn, a, we, wd, held, hung);
         e = sb.pop_front();
         n_cmp++; if (sn !== 0 || rn !== 0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL illegal%0d_noreq stall_n=%0d req_n=%0d want 0 0", i, sn, rn); end
         n_cmp++; if (misaligned_mw !== e.mis || rddata_mw !== e.rd || bus_error_mw !== e.berr) begin
            n_err++; $display("FAIL illegal%0d_flags mis=%b rd=%h berr=%b want 1 0 0", i, misaligned_mw, rddata_mw, bus_error_mw);
         end
         end_phase();
      end
   endtask

   task automatic test_timeout();
      int sn, rn; logic [31:0] a, wd; logic [3:0] we; bit held, hung; exp_t e;
      sb.push_back('{32'h0, 1'b0, 1'b1, 5'h0A, 32'hB00});
      model_rd = '0;
      run_access(mkop(1, 0, 3'b010), 32'h400, 32'h0, 32'h1234_5678, 5'h0A, 32'hB00, 0,
                 sn, rn, a, we, wd, held, hung);
      e = sb.pop_front();
      n_cmp++; if (rn !== 4 || sn !== 5 || hung) begin n_err++; $display("FAIL timeout_len req_n=%0d stall_n=%0d want 4 5", rn, sn); end
      n_cmp++; if (bus_error_mw !== e.berr || rddata_mw !== e.rd || misaligned_mw !== e.mis) begin
         n_err++; $display("FAIL timeout_flags berr=%b rd=%h mis=%b want 1 0 0", bus_error_mw, rddata_mw, misaligned_mw);
      end
      n_cmp++; if (dmem_req !== 1'b0 || stall_memoryaccess !== 1'b0) begin n_err++; $display("FAIL timeout_release req=%b stall=%b want 0 0", dmem_req, stall_memoryaccess); end
      end_phase();
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      decoded_op_em = mkop(1, 0, 3'b010); alu_out_em = 32'h500; rdsel_em = 5'h1C;
      next_pc_em = 32'hC00; jump_state_em = 1'b1; phase_memoryaccess = 1'b1; dmem_ack = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (dmem_req !== 1'b1 || stall_memoryaccess !== 1'b1) begin n_err++; $display("FAIL rstwait_pre req=%b stall=%b want 1 1", dmem_req, stall_memoryaccess); end
      rst = 1'b1; phase_memoryaccess = 1'b0;
      @(negedge clk); #1;
      n_cmp++; if (dmem_req !== 1'b0 || stall_memoryaccess !== 1'b0 || rdsel_mw !== 0 || next_pc_mw !== 0 ||
                  jump_state_mw !== 1'b0 || decoded_op_mw !== 0 || rddata_mw !== 0) begin
         n_err++; $display("FAIL rstwait_clear req=%b stall=%b rdsel=%h pc=%h want all zero", dmem_req, stall_memoryaccess, rdsel_mw, next_pc_mw);
      end
      rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      n_cmp++; if (dmem_req !== 1'b0 || stall_memoryaccess !== 1'b0 || rddata_mw !== 0) begin
         n_err++; $display("FAIL late_ack req=%b stall=%b rd=%h want 0 0 0", dmem_req, stall_memoryaccess, rddata_mw);
      end
      dmem_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_alu_passthrough();
      test_loads();
      test_stores();
      test_illegal();
      test_timeout();
      test_reset_in_wait();
      n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_left %0d entries want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
